// File: rtl/screen_read_arbiter.sv
// screen_read_arbiter
// Shares the CPU's single screen-memory read port between requester A (OLED
// bridge) and requester B (secondary consumer such as a frame dumper).
// Round-robin arbitration with optional per-requester frame lock, respects
// scr_busy before starting an upstream read, and aborts a read whose upstream
// ack does not arrive within ACK_TIMEOUT cycles.
//
// Handshake: a requester raises x_read with x_idx stable and holds both until
// x_ack pulses for one cycle, with x_byte valid in that same cycle. Upstream,
// scr_read is raised with scr_read_idx and held until scr_read_ack pulses for
// one cycle, with scr_read_byte valid in that cycle. An ack seen anywhere but
// ISSUE is ignored; a read still high in IDLE is a new request.
//
// ACK_TIMEOUT is meaningful over 1..65535.
module screen_read_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter bit          LOCK_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scr_busy,
    output logic       scr_read,
    output logic [7:0] scr_read_idx,
    input  logic [7:0] scr_read_byte,
    input  logic       scr_read_ack,
    input  logic       a_read,
    input  logic [7:0] a_idx,
    input  logic       a_lock,
    output logic [7:0] a_byte,
    output logic       a_ack,
    input  logic       b_read,
    input  logic [7:0] b_idx,
    input  logic       b_lock,
    output logic [7:0] b_byte,
    output logic       b_ack,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

    // Requester identity encoding used by winner/owner/last_grant: 0 = A, 1 = B.
    state_t      state_q, state_d;
    logic        scr_read_q, scr_read_d;
    logic [7:0]  scr_read_idx_q, scr_read_idx_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [7:0]  a_byte_q, a_byte_d;
    logic [7:0]  b_byte_q, b_byte_d;
    logic        timeout_err_q, timeout_err_d;
    logic        owner_valid_q, owner_valid_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        winner_q, winner_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        elig_a;
    logic        elig_b;
    logic        owner_lock;
    logic        pick_b;
    logic        pick_lock;

    // Next-state and output computation for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_d        = state_q;
        scr_read_d     = scr_read_q;
        scr_read_idx_d = scr_read_idx_q;
        a_ack_d        = 1'b0;
        b_ack_d        = 1'b0;
        a_byte_d       = a_byte_q;
        b_byte_d       = b_byte_q;
        timeout_err_d  = 1'b0;
        owner_valid_d  = owner_valid_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        winner_d       = winner_q;
        wait_cnt_d     = wait_cnt_q;
        elig_a         = a_read;
        elig_b         = b_read;
        owner_lock     = owner_q ? b_lock : a_lock;
        pick_b         = 1'b0;
        pick_lock      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A held lock narrows eligibility to the owner; a dropped lock releases it.
                if (LOCK_EN && owner_valid_q) begin
                    if (owner_lock) begin
                        elig_a = a_read & ~owner_q;
                        elig_b = b_read & owner_q;
                    end else begin
                        owner_valid_d = 1'b0;
                    end
                end
                // On a tie B wins only if A had the previous grant.
                pick_b    = elig_b & (~elig_a | ~last_grant_q);
                pick_lock = pick_b ? b_lock : a_lock;
                if ((elig_a || elig_b) && !scr_busy) begin
                    winner_d       = pick_b;
                    last_grant_d   = pick_b;
                    scr_read_idx_d = pick_b ? b_idx : a_idx;
                    scr_read_d     = 1'b1;
                    wait_cnt_d     = 16'd0;
                    state_d        = ST_ISSUE;
                    if (LOCK_EN && pick_lock) begin
                        owner_valid_d = 1'b1;
                        owner_d       = pick_b;
                    end
                end
            end

            ST_ISSUE: begin
                // An ack in the final allowed cycle still wins over the timeout.
                wait_cnt_d = wait_cnt_q + 16'd1;
                if (scr_read_ack) begin
                    if (winner_q) begin
                        b_byte_d = scr_read_byte;
                    end else begin
                        a_byte_d = scr_read_byte;
                    end
                    scr_read_d = 1'b0;
                    a_ack_d    = ~winner_q;
                    b_ack_d    = winner_q;
                    state_d    = ST_RESP;
                end else if (wait_cnt_d >= TIMEOUT_CNT) begin
                    if (winner_q) begin
                        b_byte_d = 8'h00;
                    end else begin
                        a_byte_d = 8'h00;
                    end
                    scr_read_d    = 1'b0;
                    a_ack_d       = ~winner_q;
                    b_ack_d       = winner_q;
                    timeout_err_d = 1'b1;
                    owner_valid_d = 1'b0;
                    state_d       = ST_RESP;
                end
            end

            ST_RESP: begin
                // The ack pulse registered on the way in is visible this cycle.
                wait_cnt_d = 16'd0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            scr_read_q     <= 1'b0;
            scr_read_idx_q <= 8'h00;
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
            a_byte_q       <= 8'h00;
            b_byte_q       <= 8'h00;
            timeout_err_q  <= 1'b0;
            owner_valid_q  <= 1'b0;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            winner_q       <= 1'b0;
            wait_cnt_q     <= 16'd0;
        end else begin
            state_q        <= state_d;
            scr_read_q     <= scr_read_d;
            scr_read_idx_q <= scr_read_idx_d;
            a_ack_q        <= a_ack_d;
            b_ack_q        <= b_ack_d;
            a_byte_q       <= a_byte_d;
            b_byte_q       <= b_byte_d;
            timeout_err_q  <= timeout_err_d;
            owner_valid_q  <= owner_valid_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            winner_q       <= winner_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign scr_read     = scr_read_q;
    assign scr_read_idx = scr_read_idx_q;
    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign a_byte       = a_byte_q;
    assign b_byte       = b_byte_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_screen_read_arbiter.sv
// tb_screen_read_arbiter
// Bench for screen_read_arbiter built with ACK_TIMEOUT=8 and locks enabled.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_screen_read_arbiter;

    logic       clk;
    logic       reset;
    logic       scr_busy;
    logic       scr_read;
    logic [7:0] scr_read_idx;
    logic [7:0] scr_read_byte;
    logic       scr_read_ack;
    logic       a_read;
    logic [7:0] a_idx;
    logic       a_lock;
    logic [7:0] a_byte;
    logic       a_ack;
    logic       b_read;
    logic [7:0] b_idx;
    logic       b_lock;
    logic [7:0] b_byte;
    logic       b_ack;
    logic       timeout_err;

    screen_read_arbiter #(
        .ACK_TIMEOUT(8),
        .LOCK_EN    (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scr_busy     (scr_busy),
        .scr_read     (scr_read),
        .scr_read_idx (scr_read_idx),
        .scr_read_byte(scr_read_byte),
        .scr_read_ack (scr_read_ack),
        .a_read       (a_read),
        .a_idx        (a_idx),
        .a_lock       (a_lock),
        .a_byte       (a_byte),
        .a_ack        (a_ack),
        .b_read       (b_read),
        .b_idx        (b_idx),
        .b_lock       (b_lock),
        .b_byte       (b_byte),
        .b_ack        (b_ack),
        .timeout_err  (timeout_err)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, actual=hang required=finish");
        $fatal(1, "watchdog expired");
    end

    // Bench state
    typedef struct {
        logic       port;
        logic [7:0] idx;
        logic [7:0] data;
        int         lat;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vecs[8];
    int         checks;
    int         errors;
    logic [7:0] up_mem[256];
    int         up_lat;
    int         up_cnt;
    logic       up_never;
    logic       lat_rand;
    logic       busy_rand;
    logic       gap_en;
    logic       drv_en;
    logic       sb_en;
    logic       stray_next;
    int         gap_a;
    int         gap_b;
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock step: upstream responder, scoreboard, requester drivers.
    task automatic tick();
        logic [8:0] exp_e;
        @(posedge clk);
        #1;
        scr_read_ack = 1'b0;
        if (stray_next) begin
            scr_read_ack  = 1'b1;
            scr_read_byte = 8'hEE;
            stray_next    = 1'b0;
        end else if (scr_read && !up_never) begin
            if (up_cnt >= up_lat) begin
                scr_read_ack  = 1'b1;
                scr_read_byte = up_mem[scr_read_idx];
                up_cnt        = 0;
                if (lat_rand) up_lat = $urandom_range(0, 5);
            end else begin
                up_cnt++;
            end
        end else begin
            up_cnt = 0;
        end

        if (sb_en && (a_ack || b_ack)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ack: actual a_ack=%0b b_ack=%0b required=no ack", a_ack, b_ack);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_grant_port_byte", {b_ack, (b_ack ? b_byte : a_byte)}, exp_e);
                check("sb_single_ack", a_ack & b_ack, 0);
                check("sb_no_timeout", timeout_err, 0);
            end
        end

        if (drv_en) begin
            if (a_ack && a_read) begin
                void'(qa.pop_front());
                a_read = 1'b0;
                a_lock = 1'b0;
                gap_a  = gap_en ? $urandom_range(0, 4) : 0;
            end
            if (!a_read && qa.size() > 0) begin
                if (gap_a == 0) begin
                    a_read = 1'b1;
                    a_lock = qa[0][8];
                    a_idx  = qa[0][7:0];
                end else begin
                    gap_a--;
                end
            end
            if (b_ack && b_read) begin
                void'(qb.pop_front());
                b_read = 1'b0;
                b_lock = 1'b0;
                gap_b  = gap_en ? $urandom_range(0, 4) : 0;
            end
            if (!b_read && qb.size() > 0) begin
                if (gap_b == 0) begin
                    b_read = 1'b1;
                    b_lock = qb[0][8];
                    b_idx  = qb[0][7:0];
                end else begin
                    gap_b--;
                end
            end
        end

        if (busy_rand) scr_busy = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset(input string name);
        reset      = 1'b1;
        a_read     = 1'b0;
        b_read     = 1'b0;
        a_lock     = 1'b0;
        b_lock     = 1'b0;
        scr_busy   = 1'b0;
        stray_next = 1'b0;
        tick();
        check({name, "_scr_read"}, scr_read, 0);
        check({name, "_scr_read_idx"}, scr_read_idx, 0);
        check({name, "_a_ack"}, a_ack, 0);
        check({name, "_b_ack"}, b_ack, 0);
        check({name, "_a_byte"}, a_byte, 0);
        check({name, "_b_byte"}, b_byte, 0);
        check({name, "_timeout_err"}, timeout_err, 0);
        tick();
        reset = 1'b0;
    endtask

    // Reference model: order of grants from the arbitration rules, assuming
    // every requester with work left is presenting at each arbitration point.
    task automatic build_expected();
        logic last_b, own_v, own_b, ea, eb, la, lb, w;
        int   ia, ib;
        last_b = 1'b1;
        own_v  = 1'b0;
        own_b  = 1'b0;
        ia     = 0;
        ib     = 0;
        while (ia < qa.size() || ib < qb.size()) begin
            ea = (ia < qa.size());
            eb = (ib < qb.size());
            la = ea && qa[ia][8];
            lb = eb && qb[ib][8];
            if (own_v) begin
                if (!own_b && la) eb = 1'b0;
                else if (own_b && lb) ea = 1'b0;
                else own_v = 1'b0;
            end
            w      = (ea && eb) ? !last_b : eb;
            last_b = w;
            if (w ? lb : la) begin
                own_v = 1'b1;
                own_b = w;
            end
            if (w) begin
                exp_q.push_back({1'b1, up_mem[qb[ib][7:0]]});
                ib++;
            end else begin
                exp_q.push_back({1'b0, up_mem[qa[ia][7:0]]});
                ia++;
            end
        end
    endtask

    task automatic run_phase(input string name);
        int n;
        n      = 0;
        drv_en = 1'b1;
        sb_en  = 1'b1;
        gap_a  = 0;
        gap_b  = 0;
        while ((qa.size() > 0 || qb.size() > 0 || exp_q.size() > 0 || a_read || b_read) && n < 4000) begin
            tick();
            n++;
        end
        check({name, "_completed"}, (n < 4000), 1);
        qa.delete();
        qb.delete();
        exp_q.delete();
        drv_en    = 1'b0;
        sb_en     = 1'b0;
        busy_rand = 1'b0;
        scr_busy  = 1'b0;
        a_read    = 1'b0;
        b_read    = 1'b0;
        tick();
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic prev;
        logic got;
        int   n;
        up_mem[v.idx] = v.data;
        up_lat        = v.lat;
        up_never      = 1'b0;
        if (v.port) begin
            b_read = 1'b1;
            b_idx  = v.idx;
            b_lock = 1'b0;
        end else begin
            a_read = 1'b1;
            a_idx  = v.idx;
            a_lock = 1'b0;
        end
        tick();
        check($sformatf("vec%0d_issue_latency", k), scr_read, 1);
        check($sformatf("vec%0d_idx", k), scr_read_idx, v.idx);
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            prev = scr_read_ack;
            tick();
            n++;
            if (prev) begin
                got = 1'b1;
                check($sformatf("vec%0d_ack_cycle", k), n, v.lat + 1);
                check($sformatf("vec%0d_own_ack", k), v.port ? b_ack : a_ack, 1);
                check($sformatf("vec%0d_other_ack", k), v.port ? a_ack : b_ack, 0);
                check($sformatf("vec%0d_byte", k), v.port ? b_byte : a_byte, v.exp_byte);
                check($sformatf("vec%0d_no_timeout", k), timeout_err, 0);
                a_read = 1'b0;
                b_read = 1'b0;
            end
        end
        check($sformatf("vec%0d_ack_seen", k), got, 1);
        a_read = 1'b0;
        b_read = 1'b0;
        tick();
        check($sformatf("vec%0d_ack_one_cycle", k), a_ack | b_ack, 0);
    endtask

    // Test sequence
    initial begin
        int   n;
        logic got;
        int   na;
        int   nb;

        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        scr_busy      = 1'b0;
        scr_read_byte = 8'h00;
        scr_read_ack  = 1'b0;
        a_read        = 1'b0;
        a_idx         = 8'h00;
        a_lock        = 1'b0;
        b_read        = 1'b0;
        b_idx         = 8'h00;
        b_lock        = 1'b0;
        up_lat        = 1;
        up_cnt        = 0;
        up_never      = 1'b0;
        lat_rand      = 1'b0;
        busy_rand     = 1'b0;
        gap_en        = 1'b0;
        drv_en        = 1'b0;
        sb_en         = 1'b0;
        stray_next    = 1'b0;
        gap_a         = 0;
        gap_b         = 0;
        for (int i = 0; i < 256; i++) up_mem[i] = 8'($urandom_range(0, 255));

        vecs[0] = '{1'b0, 8'h2A, 8'h5C, 2, 8'h5C};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 0, 8'hFF};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 1, 8'h00};
        vecs[3] = '{1'b1, 8'h80, 8'h3C, 7, 8'h3C};
        vecs[4] = '{1'b0, 8'h01, 8'hA5, 3, 8'hA5};
        vecs[5] = '{1'b1, 8'h7E, 8'h11, 5, 8'h11};
        vecs[6] = '{1'b0, 8'h10, 8'hC3, 0, 8'hC3};
        vecs[7] = '{1'b1, 8'h2B, 8'h69, 4, 8'h69};

        // Single transactions from the vector table
        do_reset("rst0");
        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Both requesting, no locks: A,B,A,B
        do_reset("rst_alt");
        up_lat = 1;
        qa.push_back(9'h010);
        qa.push_back(9'h011);
        qb.push_back(9'h020);
        qb.push_back(9'h021);
        exp_q.push_back({1'b0, up_mem[8'h10]});
        exp_q.push_back({1'b1, up_mem[8'h20]});
        exp_q.push_back({1'b0, up_mem[8'h11]});
        exp_q.push_back({1'b1, up_mem[8'h21]});
        run_phase("alternate");

        // A locked for four reads, then B on the first unlocked arbitration
        do_reset("rst_lock");
        up_lat = 1;
        for (int i = 0; i < 4; i++) qa.push_back({1'b1, 8'(i)});
        qa.push_back(9'h004);
        qb.push_back(9'h030);
        qb.push_back(9'h031);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, up_mem[i]});
        exp_q.push_back({1'b1, up_mem[8'h30]});
        exp_q.push_back({1'b0, up_mem[8'h04]});
        exp_q.push_back({1'b1, up_mem[8'h31]});
        run_phase("lock");

        // scr_busy holds off a new read but not an in-flight one
        do_reset("rst_busy");
        up_never      = 1'b0;
        up_lat        = 1;
        up_mem[8'h55] = 8'h9D;
        scr_busy      = 1'b1;
        a_read        = 1'b1;
        a_idx         = 8'h55;
        a_lock        = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (scr_read) n++;
        end
        check("busy_hold_cycles", n, 0);
        scr_busy = 1'b0;
        tick();
        check("busy_release_issue", scr_read, 1);
        check("busy_release_idx", scr_read_idx, 8'h55);
        scr_busy = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (a_ack) begin
                got = 1'b1;
                check("busy_inflight_byte", a_byte, 8'h9D);
                a_read = 1'b0;
            end
        end
        check("busy_inflight_done", got, 1);
        scr_busy = 1'b0;
        a_read   = 1'b0;
        tick();

        // Timeout: upstream never acks
        up_never = 1'b1;
        a_read   = 1'b1;
        a_idx    = 8'h77;
        tick();
        n = 0;
        while (scr_read && n < 50) begin
            n++;
            tick();
        end
        check("to_read_cycles", n, 8);
        check("to_err_pulse", timeout_err, 1);
        check("to_a_ack", a_ack, 1);
        check("to_a_byte", a_byte, 8'h00);
        check("to_b_ack", b_ack, 0);
        a_read = 1'b0;
        tick();
        tick();
        stray_next = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_ack || b_ack || timeout_err || scr_read) n++;
        end
        check("to_late_ack_ignored", n, 0);
        check("to_byte_kept", a_byte, 8'h00);

        // Reset while a read is in flight
        up_never = 1'b1;
        a_read   = 1'b1;
        a_idx    = 8'h33;
        tick();
        tick();
        check("rst_issue_pre_read", scr_read, 1);
        do_reset("rst_issue");
        up_never   = 1'b0;
        up_lat     = 2;
        stray_next = 1'b1;
        tick();
        tick();
        check("rst_stray_ignored", {a_ack, b_ack, scr_read}, 0);
        qa.push_back(9'h003);
        qb.push_back(9'h004);
        exp_q.push_back({1'b0, up_mem[8'h03]});
        exp_q.push_back({1'b1, up_mem[8'h04]});
        run_phase("tie_after_reset");

        // Random: both requesters busy, random locks, latency and scr_busy
        for (int r = 0; r < 12; r++) begin
            do_reset($sformatf("rst_rd%0d", r));
            up_never  = 1'b0;
            lat_rand  = 1'b1;
            up_lat    = $urandom_range(0, 5);
            busy_rand = 1'b1;
            gap_en    = 1'b0;
            na = $urandom_range(3, 8);
            nb = $urandom_range(3, 8);
            for (int i = 0; i < na; i++) qa.push_back({($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255))});
            for (int i = 0; i < nb; i++) qb.push_back({($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255))});
            build_expected();
            run_phase("rand_dual");
        end

        // Random: one requester with gaps between its reads
        for (int r = 0; r < 8; r++) begin
            do_reset($sformatf("rst_rs%0d", r));
            lat_rand  = 1'b1;
            up_lat    = $urandom_range(0, 5);
            busy_rand = 1'b1;
            gap_en    = 1'b1;
            na = $urandom_range(2, 6);
            for (int i = 0; i < na; i++) begin
                if (r % 2 == 0) qa.push_back({($urandom_range(0, 1) == 0), 8'($urandom_range(0, 255))});
                else qb.push_back({($urandom_range(0, 1) == 0), 8'($urandom_range(0, 255))});
            end
            build_expected();
            run_phase("rand_single");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
